// File: rtl/icache_if.sv
// Fetch-side and memory-side signals of the direct-mapped instruction cache.
// The slave view belongs to the cache. The master view is the datapath and memory together.
interface icache_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        flush;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport slave (
    input  imemREN, imemaddr, flush, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, flush, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache with zero-wait hits and
// a blocking IDLE/FILL refill engine that always completes to the latched miss address.
module icache #(
  parameter int SETS = 16
) (
  input  logic    CLK,
  input  logic    RST,
  icache_if.slave bus
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  state_t            state;
  state_t            next_state;

  logic [SETS-1:0]   valid;
  logic [TAG_W-1:0]  tag_arr  [SETS];
  logic [31:0]       data_arr [SETS];
  logic [31:0]       miss_addr;
  logic              drop;

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  fill_idx;
  logic [TAG_W-1:0]  fill_tag;
  logic              hit;
  logic              miss;
  logic              fill_done;
  logic              fill_we;
  logic              unused_byte_bits;

  assign req_idx  = bus.imemaddr[IDX_W+1:2];
  assign req_tag  = bus.imemaddr[31:IDX_W+2];
  assign fill_idx = miss_addr[IDX_W+1:2];
  assign fill_tag = miss_addr[31:IDX_W+2];
  assign unused_byte_bits = ^bus.imemaddr[1:0];

  // A flush in flight hides every line, including the one being probed this cycle.
  assign hit = (state == IDLE) && bus.imemREN && !bus.flush &&
               valid[req_idx] && (tag_arr[req_idx] == req_tag);
  assign miss      = (state == IDLE) && bus.imemREN && !hit;
  assign fill_done = (state == FILL) && !bus.iwait;
  // A fill overlapped by any flush is discarded so stale data never becomes visible.
  assign fill_we   = fill_done && !drop && !bus.flush;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (miss)      next_state = FILL;
      FILL: if (fill_done) next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.ihit     = 1'b0;
    bus.imemload = '0;
    bus.iREN     = 1'b0;
    bus.iaddr    = '0;
    case (state)
      IDLE: begin
        bus.ihit     = hit;
        bus.imemload = hit ? data_arr[req_idx] : '0;
      end
      FILL: begin
        bus.iREN  = 1'b1;
        bus.iaddr = miss_addr;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid <= '0;
    end else if (bus.flush) begin
      valid <= '0;
    end else if (fill_we) begin
      valid[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      miss_addr <= '0;
    end else if (miss) begin
      miss_addr <= {bus.imemaddr[31:2], 2'b00};
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      drop <= 1'b0;
    end else if (state == FILL) begin
      drop <= fill_done ? 1'b0 : (drop | bus.flush);
    end else begin
      drop <= 1'b0;
    end
  end

  // Tag and data storage carry no reset; the valid bits alone decide hits.
  always_ff @(posedge CLK) begin
    if (fill_we) begin
      tag_arr[fill_idx]  <= fill_tag;
      data_arr[fill_idx] <= bus.iload;
    end
  end
endmodule
